// File: rtl/atm_pkg.sv
// Shared types and default sizing for the card session controller.
// The FSM state encoding lives here so the controller and any monitors agree on it.
package atm_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_PSW = 2'd1,
      SESSION  = 2'd2
   } state_t;

   localparam int DEF_CARD_W      = 6;
   localparam int DEF_PSW_W       = 16;
   localparam int DEF_BAL_W       = 20;
   localparam int DEF_USERS_NUM   = 10;
   localparam int DEF_MAX_TRIES   = 3;
   localparam int DEF_TIMEOUT_CYC = 1024;

endpackage

// File: rtl/account_table.sv
// Account storage: password/balance arrays (not reset) and per-account lock bits (reset).
// Reads are combinational from one shared address; out-of-range addresses read as zero.
module account_table #(
   parameter int CARD_W    = 6,
   parameter int PSW_W     = 16,
   parameter int BAL_W     = 20,
   parameter int USERS_NUM = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_we,
   input  logic [CARD_W-1:0] cfg_addr,
   input  logic [PSW_W-1:0]  cfg_password,
   input  logic [BAL_W-1:0]  cfg_balance,
   input  logic [CARD_W-1:0] addr,
   input  logic              bal_we,
   input  logic [BAL_W-1:0]  bal_data,
   input  logic              lock_set,
   output logic [PSW_W-1:0]  rd_password,
   output logic [BAL_W-1:0]  rd_balance,
   output logic              rd_locked
);

   localparam int IDX_W = (USERS_NUM > 1) ? $clog2(USERS_NUM) : 1;
   localparam logic [CARD_W:0] USERS_LIM = (CARD_W+1)'(USERS_NUM);

   logic [PSW_W-1:0]     psw_mem [0:USERS_NUM-1];
   logic [BAL_W-1:0]     bal_mem [0:USERS_NUM-1];
   logic [USERS_NUM-1:0] lock_q;

   logic             cfg_hit;
   logic             addr_hit;
   logic [IDX_W-1:0] cfg_idx;
   logic [IDX_W-1:0] idx;

   always_comb begin
      cfg_hit  = ({1'b0, cfg_addr} < USERS_LIM);
      addr_hit = ({1'b0, addr} < USERS_LIM);
      cfg_idx  = cfg_addr[IDX_W-1:0];
      idx      = addr[IDX_W-1:0];
   end

   // Contents survive reset by design; only the lock bits are cleared.
   always_ff @(posedge clk) begin
      if (cfg_we && cfg_hit) begin
         psw_mem[cfg_idx] <= cfg_password;
         bal_mem[cfg_idx] <= cfg_balance;
      end else if (bal_we && addr_hit) begin
         bal_mem[idx] <= bal_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lock_q <= '0;
      end else if (cfg_we && cfg_hit) begin
         lock_q[cfg_idx] <= 1'b0;
      end else if (lock_set && addr_hit) begin
         lock_q[idx] <= 1'b1;
      end
   end

   always_comb begin
      rd_password = '0;
      rd_balance  = '0;
      rd_locked   = 1'b0;
      if (addr_hit) begin
         rd_password = psw_mem[idx];
         rd_balance  = bal_mem[idx];
         rd_locked   = lock_q[idx];
      end
   end

endmodule

// File: rtl/card_session_ctrl.sv
// Card session controller: card insertion, password check with lockout, balance
// commit, eject and inactivity timeout. All outputs are registered.
module card_session_ctrl
   import atm_pkg::*;
#(
   parameter int CARD_W      = DEF_CARD_W,
   parameter int PSW_W       = DEF_PSW_W,
   parameter int BAL_W       = DEF_BAL_W,
   parameter int USERS_NUM   = DEF_USERS_NUM,
   parameter int MAX_TRIES   = DEF_MAX_TRIES,
   parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           card_in,
   input  logic [CARD_W-1:0]              card_number,
   input  logic                           psw_valid,
   input  logic [PSW_W-1:0]               password_input,
   input  logic                           op_done,
   input  logic [BAL_W-1:0]               updated_balance,
   input  logic                           card_out,
   input  logic                           cfg_we,
   input  logic [CARD_W-1:0]              cfg_addr,
   input  logic [PSW_W-1:0]               cfg_password,
   input  logic [BAL_W-1:0]               cfg_balance,
   output logic                           psw_en,
   output logic                           session_active,
   output logic [BAL_W-1:0]               balance,
   output logic [$clog2(MAX_TRIES+1)-1:0] tries_left,
   output logic                           wrong_id,
   output logic                           wrong_psw,
   output logic                           card_locked,
   output logic                           timeout
);

   localparam int TRY_W = $clog2(MAX_TRIES+1);
   localparam int CNT_W = $clog2(TIMEOUT_CYC+1);
   localparam logic [CARD_W:0] USERS_LIM = (CARD_W+1)'(USERS_NUM);

   state_t            state;
   logic [CARD_W-1:0] id_q;
   logic [CNT_W-1:0]  idle_cnt;

   logic              id_ok;
   logic              psw_match;
   logic              last_try;
   logic              cnt_expired;
   logic [CARD_W-1:0] acc_addr;
   logic              tbl_cfg_we;
   logic              tbl_bal_we;
   logic              tbl_lock_set;
   logic [PSW_W-1:0]  rd_password;
   logic [BAL_W-1:0]  rd_balance;
   logic              rd_locked;

   // The table is addressed by the presented card in IDLE and by the latched id otherwise.
   always_comb begin
      acc_addr     = (state == IDLE) ? card_number : id_q;
      id_ok        = ({1'b0, card_number} < USERS_LIM);
      psw_match    = (password_input == rd_password);
      last_try     = (tries_left == TRY_W'(1));
      cnt_expired  = (idle_cnt == CNT_W'(TIMEOUT_CYC-1));
      tbl_cfg_we   = cfg_we && (state == IDLE);
      tbl_bal_we   = op_done && (state == SESSION);
      tbl_lock_set = (state == WAIT_PSW) && psw_valid && !card_out && !psw_match && last_try;
   end

   account_table #(
      .CARD_W   (CARD_W),
      .PSW_W    (PSW_W),
      .BAL_W    (BAL_W),
      .USERS_NUM(USERS_NUM)
   ) u_account_table (
      .clk         (clk),
      .rst         (rst),
      .cfg_we      (tbl_cfg_we),
      .cfg_addr    (cfg_addr),
      .cfg_password(cfg_password),
      .cfg_balance (cfg_balance),
      .addr        (acc_addr),
      .bal_we      (tbl_bal_we),
      .bal_data    (updated_balance),
      .lock_set    (tbl_lock_set),
      .rd_password (rd_password),
      .rd_balance  (rd_balance),
      .rd_locked   (rd_locked)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state          <= IDLE;
         id_q           <= '0;
         idle_cnt       <= '0;
         psw_en         <= 1'b0;
         session_active <= 1'b0;
         balance        <= '0;
         tries_left     <= '0;
         wrong_id       <= 1'b0;
         wrong_psw      <= 1'b0;
         card_locked    <= 1'b0;
         timeout        <= 1'b0;
      end else begin
         wrong_id    <= 1'b0;
         wrong_psw   <= 1'b0;
         card_locked <= 1'b0;
         timeout     <= 1'b0;

         case (state)
            IDLE: begin
               if (card_in) begin
                  if (!id_ok) begin
                     wrong_id <= 1'b1;
                  end else if (rd_locked) begin
                     card_locked <= 1'b1;
                  end else begin
                     state      <= WAIT_PSW;
                     id_q       <= card_number;
                     tries_left <= TRY_W'(MAX_TRIES);
                     idle_cnt   <= '0;
                     psw_en     <= 1'b1;
                  end
               end
            end

            WAIT_PSW: begin
               // Eject takes priority so a simultaneous password is never counted.
               if (card_out) begin
                  state      <= IDLE;
                  psw_en     <= 1'b0;
                  tries_left <= '0;
                  idle_cnt   <= '0;
               end else if (psw_valid) begin
                  idle_cnt <= '0;
                  if (psw_match) begin
                     state          <= SESSION;
                     psw_en         <= 1'b0;
                     session_active <= 1'b1;
                     balance        <= rd_balance;
                  end else begin
                     wrong_psw  <= 1'b1;
                     tries_left <= tries_left - TRY_W'(1);
                     if (last_try) begin
                        state       <= IDLE;
                        psw_en      <= 1'b0;
                        card_locked <= 1'b1;
                     end
                  end
               end else if (cnt_expired) begin
                  state      <= IDLE;
                  psw_en     <= 1'b0;
                  tries_left <= '0;
                  idle_cnt   <= '0;
                  timeout    <= 1'b1;
               end else begin
                  idle_cnt <= idle_cnt + CNT_W'(1);
               end
            end

            SESSION: begin
               // A same-cycle op_done still reaches the table through tbl_bal_we.
               if (card_out) begin
                  state          <= IDLE;
                  session_active <= 1'b0;
                  balance        <= '0;
                  tries_left     <= '0;
                  idle_cnt       <= '0;
               end else if (op_done) begin
                  balance  <= updated_balance;
                  idle_cnt <= '0;
               end else if (cnt_expired) begin
                  state          <= IDLE;
                  session_active <= 1'b0;
                  balance        <= '0;
                  tries_left     <= '0;
                  idle_cnt       <= '0;
                  timeout        <= 1'b1;
               end else begin
                  idle_cnt <= idle_cnt + CNT_W'(1);
               end
            end

            default: begin
               state          <= IDLE;
               psw_en         <= 1'b0;
               session_active <= 1'b0;
               balance        <= '0;
               tries_left     <= '0;
               idle_cnt       <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_card_session_ctrl.sv
// Directed bench for card_session_ctrl: login, commit+eject, lockout, bad id,
// timeout and mid-session reset, with hand-computed expectations.
module tb_card_session_ctrl;

   localparam int CARD_W  = 6;
   localparam int PSW_W   = 16;
   localparam int BAL_W   = 20;
   localparam int TRY_W   = 2;
   localparam int TIMEOUT = 16;

   logic              clk;
   logic              rst;
   logic              card_in;
   logic [CARD_W-1:0] card_number;
   logic              psw_valid;
   logic [PSW_W-1:0]  password_input;
   logic              op_done;
   logic [BAL_W-1:0]  updated_balance;
   logic              card_out;
   logic              cfg_we;
   logic [CARD_W-1:0] cfg_addr;
   logic [PSW_W-1:0]  cfg_password;
   logic [BAL_W-1:0]  cfg_balance;
   logic              psw_en;
   logic              session_active;
   logic [BAL_W-1:0]  balance;
   logic [TRY_W-1:0]  tries_left;
   logic              wrong_id;
   logic              wrong_psw;
   logic              card_locked;
   logic              timeout;

   int n_checks = 0;
   int n_errors = 0;

   card_session_ctrl #(
      .CARD_W     (CARD_W),
      .PSW_W      (PSW_W),
      .BAL_W      (BAL_W),
      .USERS_NUM  (10),
      .MAX_TRIES  (3),
      .TIMEOUT_CYC(TIMEOUT)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .card_in        (card_in),
      .card_number    (card_number),
      .psw_valid      (psw_valid),
      .password_input (password_input),
      .op_done        (op_done),
      .updated_balance(updated_balance),
      .card_out       (card_out),
      .cfg_we         (cfg_we),
      .cfg_addr       (cfg_addr),
      .cfg_password   (cfg_password),
      .cfg_balance    (cfg_balance),
      .psw_en         (psw_en),
      .session_active (session_active),
      .balance        (balance),
      .tries_left     (tries_left),
      .wrong_id       (wrong_id),
      .wrong_psw      (wrong_psw),
      .card_locked    (card_locked),
      .timeout        (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic cfg_write(input int id, input int psw, input int bal);
      cfg_we       = 1'b1;
      cfg_addr     = CARD_W'(id);
      cfg_password = PSW_W'(psw);
      cfg_balance  = BAL_W'(bal);
      tick(1);
      cfg_we = 1'b0;
   endtask

   task automatic insert(input int id);
      card_in     = 1'b1;
      card_number = CARD_W'(id);
      tick(1);
      card_in = 1'b0;
   endtask

   task automatic enter_psw(input int psw);
      psw_valid      = 1'b1;
      password_input = PSW_W'(psw);
      tick(1);
      psw_valid = 1'b0;
   endtask

   task automatic eject();
      card_out = 1'b1;
      tick(1);
      card_out = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, ".psw_en"}, 32'(psw_en), 0);
      check({tag, ".session_active"}, 32'(session_active), 0);
      check({tag, ".balance"}, 32'(balance), 0);
      check({tag, ".tries_left"}, 32'(tries_left), 0);
      check({tag, ".pulses"}, 32'({wrong_id, wrong_psw, card_locked, timeout}), 0);
   endtask

   initial begin
      rst = 1'b0;
      card_in = 1'b0; card_number = '0; psw_valid = 1'b0; password_input = '0;
      op_done = 1'b0; updated_balance = '0; card_out = 1'b0;
      cfg_we = 1'b0; cfg_addr = '0; cfg_password = '0; cfg_balance = '0;
      tick(3);
      check_all_zero("reset");
      rst = 1'b1;
      tick(1);

      // Basic login on account 3.
      cfg_write(3, 'h1234, 500);
      insert(3);
      check("insert3.psw_en", 32'(psw_en), 1);
      check("insert3.tries", 32'(tries_left), 3);
      enter_psw('h1234);
      check("login.session", 32'(session_active), 1);
      check("login.balance", 32'(balance), 500);
      check("login.psw_en", 32'(psw_en), 0);

      // op_done and card_out together: commit then leave.
      op_done = 1'b1; updated_balance = BAL_W'(450); card_out = 1'b1;
      tick(1);
      op_done = 1'b0; card_out = 1'b0;
      check("commit_eject.session", 32'(session_active), 0);
      check("commit_eject.balance", 32'(balance), 0);
      insert(3);
      enter_psw('h1234);
      check("relogin.balance", 32'(balance), 450);
      eject();
      check("eject.session", 32'(session_active), 0);

      // Eject in the same cycle as a wrong password: no attempt counted.
      insert(3);
      psw_valid = 1'b1; password_input = PSW_W'('h1111); card_out = 1'b1;
      tick(1);
      psw_valid = 1'b0; card_out = 1'b0;
      check("eject_psw.wrong_psw", 32'(wrong_psw), 0);
      check("eject_psw.psw_en", 32'(psw_en), 0);

      // Three wrong passwords lock the account.
      insert(3);
      check("lock.start_tries", 32'(tries_left), 3);
      enter_psw('h1111);
      check("lock.w1.wrong_psw", 32'(wrong_psw), 1);
      check("lock.w1.tries", 32'(tries_left), 2);
      check("lock.w1.locked", 32'(card_locked), 0);
      tick(1);
      check("lock.pulse_clear", 32'(wrong_psw), 0);
      enter_psw('h2222);
      check("lock.w2.wrong_psw", 32'(wrong_psw), 1);
      check("lock.w2.tries", 32'(tries_left), 1);
      enter_psw('h3333);
      check("lock.w3.wrong_psw", 32'(wrong_psw), 1);
      check("lock.w3.tries", 32'(tries_left), 0);
      check("lock.w3.locked", 32'(card_locked), 1);
      check("lock.w3.psw_en", 32'(psw_en), 0);
      insert(3);
      check("locked.card_locked", 32'(card_locked), 1);
      check("locked.psw_en", 32'(psw_en), 0);
      check("locked.wrong_id", 32'(wrong_id), 0);

      // Out-of-range card id.
      insert(12);
      check("badid.wrong_id", 32'(wrong_id), 1);
      check("badid.psw_en", 32'(psw_en), 0);
      tick(1);
      check("badid.pulse_clear", 32'(wrong_id), 0);

      // Reconfiguring clears the lock.
      cfg_write(3, 'h1234, 450);
      insert(3);
      check("unlock.psw_en", 32'(psw_en), 1);
      eject();

      // Inactivity timeout in session leaves the table untouched.
      cfg_write(5, 'hBEEF, 777);
      insert(5);
      enter_psw('hBEEF);
      check("to.login.balance", 32'(balance), 777);
      tick(TIMEOUT - 1);
      check("to.before.session", 32'(session_active), 1);
      check("to.before.timeout", 32'(timeout), 0);
      tick(1);
      check("to.fire.timeout", 32'(timeout), 1);
      check("to.fire.session", 32'(session_active), 0);
      check("to.fire.balance", 32'(balance), 0);
      insert(5);
      enter_psw('hBEEF);
      check("to.relogin.balance", 32'(balance), 777);

      // Commit, then reset mid-session.
      op_done = 1'b1; updated_balance = BAL_W'(600);
      tick(1);
      op_done = 1'b0;
      check("commit.balance", 32'(balance), 600);
      check("commit.session", 32'(session_active), 1);
      #2;
      rst = 1'b0;
      #1;
      check_all_zero("midreset");
      tick(1);
      rst = 1'b1;
      tick(1);
      insert(5);
      enter_psw('hBEEF);
      check("postreset.session", 32'(session_active), 1);
      check("postreset.balance", 32'(balance), 600);
      eject();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
